// File: rtl/if_id_skid_pkg.sv
// Shared constants and types for the fetch/decode skid pipeline register.
package if_id_skid_pkg;

  // Reset level and the all-zero instruction word (a nop bubble).
  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  // Default bus widths for the PC and instruction words.
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  // Widest fetch bundle the decoder supports.
  localparam int MaxLanes = 4;

  // Occupancy of the skid pipeline, encoded as {main_v, skid_v}.
  typedef enum logic [1:0] {
    OCC_EMPTY     = 2'b00,
    OCC_SKID_ONLY = 2'b01,  // unreachable: skid only fills behind main
    OCC_FULL      = 2'b10,
    OCC_BOTH      = 2'b11
  } occ_e;

endpackage

// File: rtl/if_id_skid_pipe_slot.sv
// One valid+data pipeline slot. Clear beats load; an empty slot always
// holds all-zero data so downstream sees a clean nop bubble.
module pipe_slot
  import if_id_skid_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Slot register: reset > clear > load, otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst == RstEnable) begin
      valid_q <= 1'b0;
      // NOTE: the data bits are reset too, because an empty slot must read
      // as an all-zero bubble rather than stale or unknown contents.
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/if_id_skid.sv
// Fetch-to-decode pipeline register with valid/ready handshake, optional
// one-entry skid buffer, flush and zeroed bubbles.
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus,
  parameter int LANES  = 1,
  parameter int SKID   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    up_valid,
  output logic                    up_ready,
  input  logic [ADDR_W-1:0]       up_pc,
  input  logic [LANES*INST_W-1:0] up_inst,
  input  logic [LANES-1:0]        up_mask,
  output logic                    dn_valid,
  input  logic                    dn_ready,
  output logic [ADDR_W-1:0]       dn_pc,
  output logic [LANES*INST_W-1:0] dn_inst,
  output logic [LANES-1:0]        dn_mask
);

  localparam int W = ADDR_W + LANES * INST_W + LANES;

  if (LANES < 1 || LANES > MaxLanes) begin : g_bad_lanes
    $error("if_id_skid: LANES must be in 1..%0d", MaxLanes);
  end

  logic [W-1:0] up_bundle;
  logic [W-1:0] main_src;
  logic [W-1:0] main_data;
  logic         main_v;
  logic         main_load;
  logic         main_clr;
  logic         consume;

  assign up_bundle = {up_pc, up_inst, up_mask};
  assign consume   = main_v & dn_ready;

  pipe_slot #(.W(W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (main_clr),
    .load_i (main_load),
    .data_i (main_src),
    .valid_o(main_v),
    .data_o (main_data)
  );

  assign dn_valid                  = main_v;
  assign {dn_pc, dn_inst, dn_mask} = main_data;

  if (SKID != 0) begin : g_skid
    logic         skid_v;
    logic         skid_load;
    logic         skid_clr;
    logic         skid_clr_any;
    logic         accept;
    logic         ready_q;
    logic [W-1:0] skid_data;
    logic         main_clr_xfer;
    occ_e         occ;

    // A bundle offered during flush is dropped even though ready is high.
    assign accept = up_valid & ready_q & ~flush;
    assign occ    = occ_e'({main_v, skid_v});

    // Next-state steering for the main and skid slots.
    always_comb begin
      // NOTE: every signal gets a default before the case so no path
      // leaves it unassigned, which would infer a latch.
      main_load     = 1'b0;
      main_src      = up_bundle;
      main_clr_xfer = 1'b0;
      skid_load     = 1'b0;
      skid_clr      = 1'b0;
      unique case (occ)
        OCC_EMPTY: main_load = accept;
        OCC_FULL: begin
          if (accept && !consume)  skid_load     = 1'b1;
          else if (accept)         main_load     = 1'b1;
          else if (consume)        main_clr_xfer = 1'b1;
        end
        OCC_BOTH: begin
          if (consume) begin
            main_load = 1'b1;
            main_src  = skid_data;
            skid_clr  = 1'b1;
          end
        end
        OCC_SKID_ONLY: skid_clr = 1'b1;
      endcase
    end

    assign main_clr     = flush | main_clr_xfer;
    assign skid_clr_any = flush | skid_clr;

    pipe_slot #(.W(W)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (skid_clr_any),
      .load_i (skid_load),
      .data_i (up_bundle),
      .valid_o(skid_v),
      .data_o (skid_data)
    );

    // Registered up_ready: tracks whether the skid entry will be free.
    always_ff @(posedge clk) begin
      if (rst == RstEnable)  ready_q <= 1'b1;
      else if (skid_clr_any) ready_q <= 1'b1;
      else if (skid_load)    ready_q <= 1'b0;
    end

    assign up_ready = ready_q;

  end else begin : g_noskid
    logic accept;

    // Combinational ready: room exists if main is empty or draining now.
    assign up_ready  = ~main_v | dn_ready;
    assign accept    = up_valid & up_ready & ~flush;
    assign main_load = accept;
    assign main_src  = up_bundle;
    assign main_clr  = flush | (consume & ~accept);
  end

endmodule
